// File: rtl/ramb4_rd_pkg.sv
// Shared definitions for the RAMB4_S8 read-stream block: default geometry,
// controller state encoding and the skid FIFO entry layout.
package ramb4_rd_pkg;

    localparam int RD_ADDR_W = 9;
    localparam int RD_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // One captured RAM byte plus the flag marking the final byte of a command.
    typedef struct packed {
        logic [RD_DATA_W-1:0] data;
        logic                 last;
    } rd_entry_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency so the stream can stall
// without losing bytes. Push and pop in the same cycle keep occupancy and order.
module rd_skid_fifo
    import ramb4_rd_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  rd_entry_t din,
    input  logic      pop,
    output rd_entry_t dout,
    output logic [1:0] count,
    output logic      empty,
    output logic      full
);

    rd_entry_t mem [0:1];
    logic      wr_ptr;
    logic      rd_ptr;

    // Storage, pointers and occupancy; flush behaves like a reset of the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/ramb4_s8_rd_stream.sv
// Read-side port master for a 512x8 synchronous block RAM. A (BASE, LEN_M1)
// command becomes a run of sequential reads with address wrap; the returned
// bytes leave as a valid/ready stream with a last marker.
// Optional macro RD_STREAM_ABORT_EN adds ABORT/ABORTED for cancelling a command.
//
// Stream handshake: a byte moves when DOUT_VALID && DOUT_READY; while VALID is
// high and READY low, DOUT, DOUT_LAST and DOUT_VALID do not change.
module ramb4_s8_rd_stream
    import ramb4_rd_pkg::*;
#(
    parameter int ADDR_W = RD_ADDR_W,
    parameter int DATA_W = RD_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    input  logic [ADDR_W-1:0] LEN_M1,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
`ifdef RD_STREAM_ABORT_EN
    input  logic              ABORT,
    output logic              ABORTED,
`endif
    output logic              DOUT_LAST
);

    rd_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic              inflight;
    logic              inflight_last;
    logic              done_r;

    logic              pop;
    logic              issue;
    logic              abort_hit;
    logic [2:0]        outstanding;

    rd_entry_t         push_entry;
    rd_entry_t         head;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

`ifdef RD_STREAM_ABORT_EN
    logic              aborted_r;
    assign abort_hit = ABORT && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // A read may be issued only if the byte it returns is guaranteed a FIFO
    // slot: count what is buffered or in flight, less the byte leaving now.
    assign pop         = !fifo_empty && DOUT_READY;
    assign outstanding = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == RUN) && (outstanding < 3'd2) && !abort_hit;

    assign push_entry.data = RAM_DO;
    assign push_entry.last = inflight_last;

    rd_skid_fifo u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (abort_hit),
        .push  (inflight),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Command FSM: latches the command, walks the address and counts issues,
    // tracks the read in flight and pulses DONE after the final handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == '0);
            if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (abort_hit) begin
                state  <= IDLE;
                done_r <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (START) begin
                            addr      <= BASE;
                            remaining <= LEN_M1;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (issue && (remaining == '0)) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && head.last) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RD_STREAM_ABORT_EN
    // ABORTED marks the DONE pulse that ends a cancelled command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= abort_hit;
        end
    end
    assign ABORTED = aborted_r;
`endif

    // The credit rule above must never let a byte arrive at a full FIFO.
    assert property (@(posedge CLK) disable iff (RST) !(inflight && fifo_full && !pop));

    assign BUSY       = (state != IDLE);
    assign DONE       = done_r;
    assign RAM_ADDR   = addr;
    assign RAM_EN     = issue;
    assign RAM_WE     = 1'b0;
    assign RAM_DI     = '0;
    assign DOUT       = head.data;
    assign DOUT_VALID = !fifo_empty;
    assign DOUT_LAST  = head.last && !fifo_empty;

endmodule
